// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - ARMv4 instruction-fetch front end: PC, branch redirect, IRQ slot insertion
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        i_branch_vld,
    input  logic [31:0] i_branch_addr,
    input  logic        i_irq_req,
    input  logic        i_irq_mask,
    output logic [31:0] o_inst_addr,
    output logic        o_inst_vld,
    output logic        o_irq_flag
);

    typedef enum logic {
        RUN      = 1'b0,
        IRQ_WAIT = 1'b1
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        irq_pend_q, irq_pend_d;
    logic [31:0] branch_target;
    logic        unused_branch_addr_bits;

    assign branch_target           = {i_branch_addr[31:2], 2'b00};
    assign unused_branch_addr_bits = ^i_branch_addr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC_ALIGNED;
            irq_pend_q <= 1'b0;
            state_q    <= RUN;
        end else begin
            pc_q       <= pc_d;
            irq_pend_q <= irq_pend_d;
            state_q    <= state_d;
        end
    end

    // A branch always wins over a pending IRQ; the IRQ is re-evaluated at the target.
    always_comb begin
        pc_d       = pc_q;
        irq_pend_d = irq_pend_q;
        state_d    = state_q;
        if (en) begin
            irq_pend_d = i_irq_req & ~i_irq_mask;
            case (state_q)
                RUN: begin
                    if (i_branch_vld) begin
                        pc_d = branch_target;
                    end else if (irq_pend_q) begin
                        state_d = IRQ_WAIT;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
                IRQ_WAIT: begin
                    if (i_branch_vld) begin
                        pc_d    = branch_target;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Slot qualifiers depend only on state and the branch input, never on en.
    always_comb begin
        o_inst_addr = pc_q;
        o_inst_vld  = (state_q == RUN) & ~i_branch_vld;
        o_irq_flag  = (state_q == RUN) & irq_pend_q & ~i_branch_vld;
    end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - scoreboard bench for if_fetch with two reset-PC instances
module tb_if_fetch;

    localparam logic [31:0] RPC0 = 32'h0000_0000;
    localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        br_vld = 1'b0;
    logic [31:0] br_addr = '0;
    logic        irq_req = 1'b0;
    logic        irq_mask = 1'b1;

    logic [31:0] addr0, addr1;
    logic        vld0, vld1, flag0, flag1;

    if_fetch #(.RESET_PC(RPC0)) dut0 (
        .clk(clk), .rst(rst), .en(en),
        .i_branch_vld(br_vld), .i_branch_addr(br_addr),
        .i_irq_req(irq_req), .i_irq_mask(irq_mask),
        .o_inst_addr(addr0), .o_inst_vld(vld0), .o_irq_flag(flag0)
    );

    if_fetch #(.RESET_PC(RPC1)) dut1 (
        .clk(clk), .rst(rst), .en(en),
        .i_branch_vld(br_vld), .i_branch_addr(br_addr),
        .i_irq_req(irq_req), .i_irq_mask(irq_mask),
        .o_inst_addr(addr1), .o_inst_vld(vld1), .o_irq_flag(flag1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] addr[2];
        logic        vld[2];
        logic        flag[2];
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: one entry per instance
    logic [31:0] m_pc[2];
    bit          m_pend[2];
    bit          m_waiting[2];
    bit          m_known = 0;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, expv);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit b, input logic [31:0] ba,
                        input bit req, input bit mask);
        exp_t x;
        logic [31:0] rpc[2];
        rpc[0] = RPC0;
        rpc[1] = RPC1;
        @(posedge clk);
        #1;
        cyc++;
        rst = r; en = e; br_vld = b; br_addr = ba; irq_req = req; irq_mask = mask;
        if (m_known) begin
            x.cyc = cyc;
            for (int k = 0; k < 2; k++) begin
                x.addr[k] = m_pc[k];
                x.vld[k]  = !m_waiting[k] && !b;
                x.flag[k] = !m_waiting[k] && m_pend[k] && !b;
            end
            exp_q.push_back(x);
        end
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_pc[k] = rpc[k]; m_pend[k] = 0; m_waiting[k] = 0;
            end else if (e) begin
                if (b) begin
                    m_pc[k] = ba & 32'hFFFF_FFFC;
                    m_waiting[k] = 0;
                end else if (!m_waiting[k] && m_pend[k]) begin
                    m_waiting[k] = 1;
                end else if (!m_waiting[k]) begin
                    m_pc[k] = m_pc[k] + 32'd4;
                end
                m_pend[k] = req && !mask;
            end
        end
        if (r) m_known = 1;
    endtask

    // Monitor: pops one expectation per cycle, sampled mid-cycle
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("addr0", x.cyc, addr0, x.addr[0]);
                chk("vld0",  x.cyc, {31'b0, vld0},  {31'b0, x.vld[0]});
                chk("flag0", x.cyc, {31'b0, flag0}, {31'b0, x.flag[0]});
                chk("addr1", x.cyc, addr1, x.addr[1]);
                chk("vld1",  x.cyc, {31'b0, vld1},  {31'b0, x.vld[1]});
                chk("flag1", x.cyc, {31'b0, flag1}, {31'b0, x.flag[1]});
            end
        end
    end

    initial begin
        bit          r, e, b, req, mask, hold;
        logic [31:0] ba;
        int          wait_cnt;

        // Reset, sequential fetch, branch to 0x103
        step(1, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 32'h103, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        // Stall with branch held and IRQ pulsed, then take the branch
        step(0, 1, 1, 32'h10, 0, 0);
        step(0, 0, 1, 32'h40, 1, 0);
        step(0, 0, 1, 32'h40, 0, 0);
        step(0, 0, 1, 32'h40, 0, 0);
        step(0, 1, 1, 32'h40, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        // IRQ at 0x20, wait, vector redirect to 0x18 with mask set
        step(0, 1, 1, 32'h20, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 0);
        step(0, 1, 1, 32'h18, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        // Masked IRQ never flags; pending IRQ collides with branch
        step(0, 1, 0, 0, 1, 1);
        step(0, 1, 0, 0, 1, 1);
        step(0, 1, 0, 0, 1, 0);
        step(0, 1, 1, 32'h200, 0, 0);
        step(0, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        // Reset while waiting for the vector branch
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);

        // Randomized traffic; branch producer holds the request until en
        hold = 0;
        ba   = 0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 149) == 0);
            e = ($urandom_range(0, 3) != 0);
            if (!hold) begin
                b = ($urandom_range(0, 6) == 0);
                ba = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
            end
            hold = b && !e && !r;
            req  = ($urandom_range(0, 3) == 0);
            mask = ($urandom_range(0, 2) == 0);
            step(r, e, b, ba, req, mask);
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
